// File: rtl/lenet_pkg.sv
// Shared definitions for the sign-magnitude datapath blocks of the LeNet engine.
package lenet_pkg;

    localparam int          SM_W        = 16;
    localparam logic [15:0] SM_NEG_ZERO = 16'h8000;
    localparam logic [14:0] MAG_MAX     = 15'h7FFF;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } arb_state_e;

    // Fold negative zero onto positive zero.
    function automatic logic [SM_W-1:0] sm_norm(input logic [SM_W-1:0] x);
        logic [SM_W-1:0] r;
        if (x == SM_NEG_ZERO) begin
            r = {SM_W{1'b0}};
        end else begin
            r = x;
        end
        return r;
    endfunction

    // Magnitude overflow of a normalised operand pair: only possible with equal signs.
    function automatic logic sm_add_ovf(input logic [SM_W-1:0] a, input logic [SM_W-1:0] b);
        logic [SM_W-1:0] mag_sum;
        mag_sum = {1'b0, a[SM_W-2:0]} + {1'b0, b[SM_W-2:0]};
        return (a[SM_W-1] == b[SM_W-1]) && (mag_sum > {1'b0, MAG_MAX});
    endfunction

endpackage

// File: rtl/sm_add_arbiter_add.sv
// Shared sign-magnitude 16-bit adder. Magnitude wraps modulo 2^15; the caller
// is responsible for operand/result normalisation and overflow reporting.
module add
    import lenet_pkg::*;
(
    input  logic [SM_W-1:0] a,
    input  logic [SM_W-1:0] b,
    output logic [SM_W-1:0] sum
);

    // Same sign: add magnitudes. Mixed sign: subtract smaller from larger.
    always_comb begin
        sum = {SM_W{1'b0}};
        if (a[SM_W-1] == b[SM_W-1]) begin
            sum = {a[SM_W-1], a[SM_W-2:0] + b[SM_W-2:0]};
        end else if (a[SM_W-2:0] >= b[SM_W-2:0]) begin
            sum = {a[SM_W-1], a[SM_W-2:0] - b[SM_W-2:0]};
        end else begin
            sum = {b[SM_W-1], b[SM_W-2:0] - a[SM_W-2:0]};
        end
    end

endmodule

// File: rtl/sm_add_arbiter.sv
// Round-robin arbiter in front of one shared sign-magnitude adder, with a
// single-entry result register that holds under backpressure.
module sm_add_arbiter
    import lenet_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [SM_W*N_REQ-1:0] req_a,
    input  logic [SM_W*N_REQ-1:0] req_b,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [SM_W-1:0]       res_data,
    output logic [ID_W-1:0]       res_id,
    output logic                  res_ovf
);

    arb_state_e      state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [SM_W-1:0] res_data_q, res_data_d;
    logic [ID_W-1:0] res_id_q, res_id_d;
    logic            res_ovf_q, res_ovf_d;

    logic            slot_free_s;
    logic            grant_vld_s;
    logic [ID_W-1:0] grant_idx_s;
    logic            transfer_s;
    logic [SM_W-1:0] a_norm_s;
    logic [SM_W-1:0] b_norm_s;
    logic [SM_W-1:0] sum_raw_s;
    logic [SM_W-1:0] sum_norm_s;
    logic            ovf_s;

    // Find the first valid requester at or after rr_ptr, wrapping upward.
    always_comb begin
        int cand;
        grant_vld_s = 1'b0;
        grant_idx_s = {ID_W{1'b0}};
        cand        = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = (int'(rr_ptr_q) + k) % N_REQ;
            if (!grant_vld_s && req_valid[cand]) begin
                grant_vld_s = 1'b1;
                grant_idx_s = ID_W'(cand);
            end else begin
                grant_vld_s = grant_vld_s;
            end
        end
    end

    // Slot availability and the transfer qualifier; nothing moves while in reset.
    always_comb begin
        slot_free_s = (state_q == ST_EMPTY) || ((state_q == ST_FULL) && res_ready);
        transfer_s  = rst_n && slot_free_s && grant_vld_s;
    end

    // Operand mux and normalisation around the shared adder.
    always_comb begin
        a_norm_s   = sm_norm(req_a[SM_W*int'(grant_idx_s) +: SM_W]);
        b_norm_s   = sm_norm(req_b[SM_W*int'(grant_idx_s) +: SM_W]);
        sum_norm_s = sm_norm(sum_raw_s);
        ovf_s      = sm_add_ovf(a_norm_s, b_norm_s);
    end

    add u_add (
        .a   (a_norm_s),
        .b   (b_norm_s),
        .sum (sum_raw_s)
    );

    // FSM next state: load on transfer, drain when consumer accepts.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (transfer_s) begin
                    state_d = ST_FULL;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (transfer_s) begin
                    state_d = ST_FULL;
                end else if (res_ready) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Result register and round-robin pointer update only on transfer.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        res_data_d = res_data_q;
        res_id_d   = res_id_q;
        res_ovf_d  = res_ovf_q;
        if (transfer_s) begin
            res_data_d = sum_norm_s;
            res_id_d   = grant_idx_s;
            res_ovf_d  = ovf_s;
            if (grant_idx_s == ID_W'(N_REQ - 1)) begin
                rr_ptr_d = {ID_W{1'b0}};
            end else begin
                rr_ptr_d = grant_idx_s + ID_W'(1);
            end
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // FSM outputs: one-hot grant on transfer, occupancy from state.
    always_comb begin
        req_ready = {N_REQ{1'b0}};
        if (transfer_s) begin
            req_ready[grant_idx_s] = 1'b1;
        end else begin
            req_ready = {N_REQ{1'b0}};
        end
        res_valid = (state_q == ST_FULL);
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q   <= {ID_W{1'b0}};
            res_data_q <= {SM_W{1'b0}};
            res_id_q   <= {ID_W{1'b0}};
            res_ovf_q  <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            res_data_q <= res_data_d;
            res_id_q   <= res_id_d;
            res_ovf_q  <= res_ovf_d;
        end
    end

    assign res_data = res_data_q;
    assign res_id   = res_id_q;
    assign res_ovf  = res_ovf_q;

endmodule

// File: tb/tb_sm_add_arbiter.sv
// Self-checking bench for sm_add_arbiter against an arithmetic reference model.
module tb_sm_add_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic [1:0]  res_id;
    logic        res_ovf;

    int errors = 0;
    int checks = 0;

    // reference model state
    logic        m_full = 1'b0;
    logic [15:0] m_data = 16'h0000;
    logic [1:0]  m_id   = 2'd0;
    logic        m_ovf  = 1'b0;
    int          m_ptr  = 0;
    int          exp_g  = -1;
    logic [3:0]  exp_ready = 4'b0000;
    logic [3:0]  obs_ready;

    sm_add_arbiter #(.N_REQ(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_ovf   (res_ovf)
    );

    always #5 clk = ~clk;

    // Signed-integer view of the sum: returns {ovf, sign, magnitude}.
    function automatic logic [16:0] ref_add(input logic [15:0] a, input logic [15:0] b);
        int va, vb, s, mag;
        logic ovf, sgn;
        va = int'(a[14:0]);
        if (a[15]) va = -va;
        vb = int'(b[14:0]);
        if (b[15]) vb = -vb;
        s   = va + vb;
        mag = (s < 0) ? -s : s;
        ovf = (mag > 32767);
        mag = mag % 32768;
        sgn = (s < 0) && (mag != 0);
        return {ovf, sgn, 15'(mag)};
    endfunction

    task automatic model_grant();
        exp_g = -1;
        exp_ready = 4'b0000;
        if (rst_n && (!m_full || res_ready)) begin
            for (int k = 0; k < 4; k++) begin
                int idx;
                idx = (m_ptr + k) % 4;
                if (exp_g < 0 && req_valid[idx]) exp_g = idx;
            end
        end
        if (exp_g >= 0) exp_ready[exp_g] = 1'b1;
    endtask

    task automatic model_commit();
        logic [16:0] r;
        if (!rst_n) begin
            m_full = 1'b0; m_data = 16'h0000; m_id = 2'd0; m_ovf = 1'b0; m_ptr = 0;
        end else if (exp_g >= 0) begin
            r = ref_add(req_a[16*exp_g +: 16], req_b[16*exp_g +: 16]);
            m_data = r[15:0];
            m_ovf  = r[16];
            m_id   = 2'(exp_g);
            m_full = 1'b1;
            m_ptr  = (exp_g + 1) % 4;
        end else if (m_full && res_ready) begin
            m_full = 1'b0;
        end
    endtask

    // One clock: sample req_ready mid-cycle, advance model with the edge, settle outputs.
    task automatic tick();
        #4;
        model_grant();
        obs_ready = req_ready;
        @(posedge clk);
        model_commit();
        #1;
    endtask

    function automatic logic [15:0] rand_op();
        logic [15:0] v;
        case ($urandom_range(0, 5))
            0: v = 16'h8000;
            1: v = 16'h7FFF;
            2: v = 16'hFFFF;
            default: v = 16'($urandom_range(0, 65535));
        endcase
        return v;
    endfunction

    task automatic rand_ops();
        for (int i = 0; i < 4; i++) begin
            req_a[16*i +: 16] = rand_op();
            req_b[16*i +: 16] = rand_op();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 4'hF; res_ready = 1'b1; rand_ops();
        tick();
        tick();
        checks++;
        if (obs_ready !== 4'b0000) begin
            errors++; $display("FAIL reset_ready: got %b want 0000", obs_ready);
        end
        checks++;
        if ({res_valid, res_data, res_id, res_ovf} !== 20'h00000) begin
            errors++; $display("FAIL reset_out: got v=%b d=%h id=%0d o=%b want all zero", res_valid, res_data, res_id, res_ovf);
        end
        rst_n = 1'b1; req_valid = 4'h0;
    endtask

    task automatic test_single();
        req_a[15:0] = 16'h0005; req_b[15:0] = 16'h8003; req_valid = 4'b0001; res_ready = 1'b1;
        tick();
        checks++;
        if (obs_ready !== 4'b0001) begin
            errors++; $display("FAIL single_ready: got %b want 0001", obs_ready);
        end
        checks++;
        if ({res_valid, res_data, res_id, res_ovf} !== {1'b1, 16'h0002, 2'd0, 1'b0}) begin
            errors++; $display("FAIL single_res: got v=%b d=%h id=%0d o=%b want v=1 d=0002 id=0 o=0", res_valid, res_data, res_id, res_ovf);
        end
        req_valid = 4'b0000;
        tick();
        checks++;
        if (res_valid !== 1'b0) begin
            errors++; $display("FAIL single_drain: got res_valid=%b want 0", res_valid);
        end
    endtask

    task automatic test_req2();
        logic [15:0] ta [3];
        logic [15:0] tb [3];
        logic [15:0] te [3];
        logic        to [3];
        ta = '{16'h8005, 16'h8000, 16'h4000};
        tb = '{16'h0003, 16'h8000, 16'h4000};
        te = '{16'h8002, 16'h0000, 16'h0000};
        to = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            req_a[47:32] = ta[i]; req_b[47:32] = tb[i]; req_valid = 4'b0100;
            tick();
            checks++;
            if (obs_ready !== 4'b0100) begin
                errors++; $display("FAIL req2_ready[%0d]: got %b want 0100", i, obs_ready);
            end
            checks++;
            if ({res_valid, res_data, res_id, res_ovf} !== {1'b1, te[i], 2'd2, to[i]}) begin
                errors++; $display("FAIL req2_res[%0d]: got v=%b d=%h id=%0d o=%b want v=1 d=%h id=2 o=%b", i, res_valid, res_data, res_id, res_ovf, te[i], to[i]);
            end
        end
        req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_round_robin();
        rand_ops(); req_valid = 4'b1000; res_ready = 1'b1;
        tick();
        for (int c = 0; c < 5; c++) begin
            rand_ops(); req_valid = 4'b1111;
            tick();
            checks++;
            if (obs_ready !== 4'(1 << (c % 4))) begin
                errors++; $display("FAIL rr_ready[%0d]: got %b want %b", c, obs_ready, 4'(1 << (c % 4)));
            end
            checks++;
            if ({res_valid, res_data, res_id, res_ovf} !== {1'b1, m_data, 2'(c % 4), m_ovf}) begin
                errors++; $display("FAIL rr_res[%0d]: got v=%b d=%h id=%0d o=%b want v=1 d=%h id=%0d o=%b", c, res_valid, res_data, res_id, res_ovf, m_data, c % 4, m_ovf);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] hold_d;
        logic [1:0]  hold_id;
        logic        hold_o;
        hold_d = m_data; hold_id = m_id; hold_o = m_ovf;
        res_ready = 1'b0; req_valid = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            rand_ops();
            tick();
            checks++;
            if (obs_ready !== 4'b0000) begin
                errors++; $display("FAIL bp_ready[%0d]: got %b want 0000", c, obs_ready);
            end
            checks++;
            if ({res_valid, res_data, res_id, res_ovf} !== {1'b1, hold_d, hold_id, hold_o}) begin
                errors++; $display("FAIL bp_hold[%0d]: got v=%b d=%h id=%0d o=%b want v=1 d=%h id=%0d o=%b", c, res_valid, res_data, res_id, res_ovf, hold_d, hold_id, hold_o);
            end
        end
        res_ready = 1'b1;
        tick();
        checks++;
        if (obs_ready !== 4'b0010) begin
            errors++; $display("FAIL bp_release_ready: got %b want 0010", obs_ready);
        end
        checks++;
        if ({res_valid, res_data, res_id, res_ovf} !== {1'b1, m_data, 2'd1, m_ovf}) begin
            errors++; $display("FAIL bp_release_res: got v=%b d=%h id=%0d o=%b want v=1 d=%h id=1 o=%b", res_valid, res_data, res_id, res_ovf, m_data, m_ovf);
        end
    endtask

    task automatic test_rr_skip();
        logic [3:0] vseq [6];
        logic       rseq [6];
        logic [3:0] rexp [6];
        vseq = '{4'b0000, 4'b0010, 4'b1010, 4'b1010, 4'b0010, 4'b0000};
        rseq = '{1'b1,    1'b1,    1'b1,    1'b1,    1'b0,    1'b1};
        rexp = '{4'b0000, 4'b0010, 4'b1000, 4'b0010, 4'b0000, 4'b0000};
        for (int i = 0; i < 6; i++) begin
            rand_ops(); req_valid = vseq[i]; res_ready = rseq[i];
            tick();
            checks++;
            if (obs_ready !== rexp[i]) begin
                errors++; $display("FAIL skip_ready[%0d]: got %b want %b", i, obs_ready, rexp[i]);
            end
            checks++;
            if ({res_valid, res_data, res_id, res_ovf} !== {m_full, m_data, m_id, m_ovf}) begin
                errors++; $display("FAIL skip_res[%0d]: got v=%b d=%h id=%0d o=%b want v=%b d=%h id=%0d o=%b", i, res_valid, res_data, res_id, res_ovf, m_full, m_data, m_id, m_ovf);
            end
        end
        req_valid = 4'b1111; res_ready = 1'b1;
        tick();
        checks++;
        if (obs_ready !== 4'b0100 || res_id !== 2'd2) begin
            errors++; $display("FAIL skip_ptr_kept: got ready=%b id=%0d want ready=0100 id=2", obs_ready, res_id);
        end
    endtask

    task automatic test_reset_full();
        res_ready = 1'b0; req_valid = 4'b1111;
        tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if (obs_ready !== 4'b0000) begin
            errors++; $display("FAIL rstfull_ready: got %b want 0000", obs_ready);
        end
        checks++;
        if ({res_valid, res_data, res_id, res_ovf} !== 20'h00000) begin
            errors++; $display("FAIL rstfull_out: got v=%b d=%h id=%0d o=%b want all zero", res_valid, res_data, res_id, res_ovf);
        end
        rst_n = 1'b1; res_ready = 1'b1; rand_ops();
        tick();
        checks++;
        if (obs_ready !== 4'b0001 || res_id !== 2'd0 || res_valid !== 1'b1) begin
            errors++; $display("FAIL rstfull_first: got ready=%b id=%0d v=%b want ready=0001 id=0 v=1", obs_ready, res_id, res_valid);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rand_ops();
            req_valid = 4'($urandom_range(0, 15));
            res_ready = ($urandom_range(0, 3) != 0);
            rst_n     = ($urandom_range(0, 59) != 0);
            tick();
            checks++;
            if (obs_ready !== exp_ready) begin
                errors++; $display("FAIL rand_ready[%0d]: got %b want %b", c, obs_ready, exp_ready);
            end
            checks++;
            if ({res_valid, res_data, res_id, res_ovf} !== {m_full, m_data, m_id, m_ovf}) begin
                errors++; $display("FAIL rand_res[%0d]: got v=%b d=%h id=%0d o=%b want v=%b d=%h id=%0d o=%b", c, res_valid, res_data, res_id, res_ovf, m_full, m_data, m_id, m_ovf);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        req_a = 64'h0; req_b = 64'h0;
        test_reset();
        test_single();
        test_req2();
        test_round_robin();
        test_backpressure();
        test_rr_skip();
        test_reset_full();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sm_add_arbiter.md
# sm_add_arbiter

Round-robin arbiter and result register that shares one sign-magnitude 16-bit adder between several requesters, e.g. the bias-add and partial-sum paths of the conv/fc layers. Each requester presents an operand pair under a valid/ready handshake. The block grants one requester per cycle and registers the sum with requester ID and overflow flag. The output stage holds under backpressure.

## Interface
- N_REQ, 4, number of requesters (2..8)
- ID_W, $clog2(N_REQ), width of requester ID
- clk  in  1  rising-edge clock (only clock)
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  N_REQ  per-requester operand valid
- req_ready  out  N_REQ  per-requester grant, one-hot or zero
- req_a  in  16*N_REQ  operand A, requester i at [16i+15:16i], sign-magnitude (bit15 sign, 14:0 magnitude)
- req_b  in  16*N_REQ  operand B, same packing
- res_valid  out  1  result register occupied
- res_ready  in  1  consumer accepts result
- res_data  out  16  sign-magnitude sum
- res_id  out  ID_W  index of requester that produced res_data
- res_ovf  out  1  magnitude overflow on this result

## Operation
- Number format: sign-magnitude. -0 (0x8000) on input is treated as +0.
- Sum equals the shared `add` output for the granted pair. Magnitude wraps modulo 2^15.
- Output normalisation: a result of 0x8000 is stored as 0x0000.
- res_ovf=1 iff the normalised operands have equal sign and |a|+|b| > 0x7FFF. Mixed signs never overflow.
- FSM, two states:
  - EMPTY: res_valid=0.
  - FULL: res_valid=1.
- slot_free = EMPTY or (FULL and res_ready).
- Grant: when slot_free and any req_valid, req_ready[g]=1 for exactly one g.
  - g is the first valid requester at or after rr_ptr, searching upward and wrapping at N_REQ-1 to 0.
  - Otherwise req_ready is all zero.
- req_ready is combinational from req_valid, rr_ptr, state and res_ready.
  - Requesters must not make req_valid depend on req_ready.
- Transfer happens when req_valid[g] and req_ready[g]. On transfer: rr_ptr <= (g+1) mod N_REQ, result register loads, state goes to FULL.
- FULL with res_ready and no transfer: state goes to EMPTY and the result register keeps stale data.
- FULL with neither res_ready nor transfer: res_data, res_id and res_ovf stay stable.
- A requester may drop req_valid without a transfer. No state changes in that case.
- rr_ptr advances only on transfer.

## Timing
- Latency: transfer on edge t, so res_valid=1 with the result from cycle t+1.
- Throughput: one result per cycle while res_ready=1, with a drain and a new grant on the same edge.
- Simultaneous drain and grant: the new result replaces the old on the same edge, and res_valid stays 1.
- Reset (rst_n=0 at an edge): res_valid=0, res_data=0, res_id=0, res_ovf=0, rr_ptr=0, state EMPTY.
  - During rst_n=0, req_ready is forced to 0.
  - An in-flight result is discarded and no transfer occurs that cycle.
- No combinational path from req_* to res_*. All res_* outputs are registers.

## Structure
- Shared package `lenet_pkg`: SM_W=16, SM_NEG_ZERO=16'h8000, MAG_MAX=15'h7FFF, state enum {ST_EMPTY, ST_FULL}.
- Operand mux, rr pointer, FSM and overflow detect are local to this block.
- One sub-module: a single instance of the existing `add` on the muxed operands. Normalisation and overflow logic sit outside `add`.

## Test plan
- Single requester 0: A=0x0005, B=0x8003. Expect res_data=0x0002, res_id=0, res_ovf=0, one cycle after transfer.
- Requester 2: A=0x8005, B=0x0003, then A=0x8000, B=0x8000. Expect 0x8002, then 0x0000. Also A=0x4000, B=0x4000: expect 0x0000 with res_ovf=1.
- All four requesters valid continuously with res_ready=1. Expect grants in order 0,1,2,3,0, one result per cycle, res_id following that order.
- res_ready=0 for 3 cycles while FULL. Expect res_data, res_id and res_ovf stable, req_ready all 0. When res_ready=1, expect drain and a new grant on the same edge.
- Requesters 1 and 3 valid with rr_ptr=2. Expect 3 granted first, then 1. Then drop valid on 1 before grant: expect no transfer and rr_ptr unchanged.
- Assert rst_n=0 while FULL with requesters valid. Expect all outputs 0 and req_ready=0 at the next edge. After release, the first grant goes to requester 0.
